// File: rtl/des_fp_serializer_if.sv
// des_fp_serializer_if: block input and byte output handshakes of the DES final-permutation stage
interface des_fp_serializer_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:32] in_l;
    logic [33:64] in_r;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    modport slave (
        input  flush, in_valid, in_l, in_r, out_ready,
        output in_ready, out_byte, out_valid, out_last, busy
    );

    modport master (
        output flush, in_valid, in_l, in_r, out_ready,
        input  in_ready, out_byte, out_valid, out_last, busy
    );
endinterface

// File: rtl/des_fp_serializer.sv
// des_fp_serializer: applies the DES final permutation to (L16,R16) and streams the block out MSB byte first
module des_fp_serializer #(
    parameter bit SWAP = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    des_fp_serializer_if.slave  bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam int FP [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    state_t      state, state_nx;
    logic [1:64] p, c, blk;
    logic [2:0]  idx;
    logic        accept;

    // preoutput selection and final permutation, bit 1 is the MSB throughout
    always_comb begin
        p = SWAP ? {bus.in_r, bus.in_l} : {bus.in_l, bus.in_r};
        c = '0;
        for (int i = 1; i <= 64; i++) c[i] = p[FP[i]];
    end

    // next state and handshake outputs; flush overrides everything
    always_comb begin
        accept        = (state == IDLE) && bus.in_valid && !bus.flush;
        bus.in_ready  = (state == IDLE) && !bus.flush;
        bus.out_valid = (state == SEND);
        bus.busy      = (state == SEND);
        bus.out_last  = (state == SEND) && (idx == 3'd7);
        bus.out_byte  = blk[8*int'(idx)+1 +: 8];
        state_nx      = state;
        if (accept) state_nx = SEND;
        if (state == SEND && bus.out_ready && idx == 3'd7) state_nx = IDLE;
        if (bus.flush) state_nx = IDLE;
    end

    // state, block capture and byte index; idx wraps 7->0 on the final byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            blk   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (accept) blk <= c;
            if (bus.flush) idx <= '0;
            else if (state == SEND && bus.out_ready) idx <= idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_des_fp_serializer.sv
// tb_des_fp_serializer: randomized and directed checks of two serializers (SWAP=1 and SWAP=0) against a reference model
module tb_des_fp_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_l = '0, in_r = '0;
    int pass_cnt = 0, total_cnt = 0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [63:0] cap_a = '0, cap_b = '0;
    int cyc = 0, last_acc = 0, acc_gap = 0, nacc = 0;

    always #5 clk = ~clk;

    des_fp_serializer_if ifa ();
    des_fp_serializer_if ifb ();

    assign ifa.flush = flush;     assign ifb.flush = flush;
    assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
    assign ifa.in_l = in_l;       assign ifb.in_l = in_l;
    assign ifa.in_r = in_r;       assign ifb.in_r = in_r;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    des_fp_serializer #(.SWAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    des_fp_serializer #(.SWAP(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // DES final permutation derived from its row/column structure rather than a table
    function automatic logic [63:0] fp_model(input logic [31:0] l, input logic [31:0] r, input bit sw);
        logic [63:0] p, c;
        int rr, cc, src;
        p = sw ? {r, l} : {l, r};
        c = '0;
        for (int i = 1; i <= 64; i++) begin
            rr = (i - 1) / 8;
            cc = (i - 1) % 8;
            src = ((cc % 2 == 0) ? 40 : 8) + 8 * (cc / 2) - rr;
            c[64 - i] = p[64 - src];
        end
        return c;
    endfunction

    // reference model: a block is a queue of pending bytes, checked every cycle before the edge
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            bit held, hs, acc;
            logic [63:0] ca, cb;
            cyc++;
            held = qa.size() != 0;
            hs = held && out_ready;
            acc = !held && in_valid && !flush;
            check("busy_a", ifa.busy, held);
            check("busy_b", ifb.busy, held);
            check("out_valid_a", ifa.out_valid, held);
            check("out_valid_b", ifb.out_valid, held);
            check("in_ready_a", ifa.in_ready, !held && !flush);
            check("in_ready_b", ifb.in_ready, !held && !flush);
            if (held) begin
                check("byte_a", ifa.out_byte, qa[0]);
                check("byte_b", ifb.out_byte, qb[0]);
                check("last_a", ifa.out_last, qa.size() == 1);
                check("last_b", ifb.out_last, qb.size() == 1);
            end else begin
                check("last_idle_a", ifa.out_last, 0);
            end
            if (hs) begin
                cap_a = {cap_a[55:0], qa.pop_front()};
                cap_b = {cap_b[55:0], qb.pop_front()};
            end
            if (flush) begin
                qa.delete();
                qb.delete();
            end
            if (acc) begin
                ca = fp_model(in_l, in_r, 1'b1);
                cb = fp_model(in_l, in_r, 1'b0);
                for (int k = 7; k >= 0; k--) begin
                    qa.push_back(ca[8*k +: 8]);
                    qb.push_back(cb[8*k +: 8]);
                end
                acc_gap = cyc - last_acc;
                last_acc = cyc;
                nacc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r);
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (qa.size() != 0 && n < 300) begin
            out_ready = ($urandom_range(0, 2) != 0);
            in_l = $urandom;
            in_r = $urandom;
            step();
            n++;
        end
        check(tag, qa.size(), 0);
    endtask

    initial begin
        repeat (2) step();
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_in_ready", ifa.in_ready, 1);
        check("rst_busy", ifa.busy, 0);
        check("rst_out_last", ifa.out_last, 0);
        check("rst_out_byte", ifa.out_byte, 8'h00);
        rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        cap_a = '0;
        send(32'h43423234, 32'h0A4CD995);
        repeat (7) step();
        check("kv_last_on_byte7", ifa.out_last, 1);
        check("kv_in_ready_low", ifa.in_ready, 0);
        step();
        check("kv_in_ready_back", ifa.in_ready, 1);
        check("kv_bytes", cap_a, 64'h85E813540F0AB405);

        cap_b = '0;
        send(32'hCC00CCFF, 32'hF0AAF0AA);
        repeat (8) step();
        check("ipinv_swap0", cap_b, 64'h0123456789ABCDEF);
        cap_a = '0;
        send(32'hF0AAF0AA, 32'hCC00CCFF);
        repeat (8) step();
        check("ipinv_swap1", cap_a, 64'h0123456789ABCDEF);

        cap_a = '0;
        out_ready = 1'b0;
        send(32'h43423234, 32'h0A4CD995);
        for (int i = 0; i < 200 && qa.size() != 0; i++) begin
            out_ready = (i < 12) ? (i % 3 == 0) : ($urandom_range(0, 3) == 0);
            in_l = $urandom;
            in_r = $urandom;
            step();
        end
        check("bp_done", qa.size(), 0);
        check("bp_bytes", cap_a, 64'h85E813540F0AB405);

        out_ready = 1'b1;
        send($urandom, $urandom);
        repeat (4) step();
        flush = 1'b1;
        step();
        check("flush_out_valid", ifa.out_valid, 0);
        flush = 1'b0;
        #1;
        check("flush_in_ready", ifa.in_ready, 1);
        cap_a = '0;
        send(32'h43423234, 32'h0A4CD995);
        repeat (8) step();
        check("flush_next_block", cap_a, 64'h85E813540F0AB405);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush_blocks_ready", ifa.in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_no_accept", ifa.busy, 0);

        send($urandom, $urandom);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", ifa.out_valid, 0);
        check("arst_busy", ifa.busy, 0);
        check("arst_in_ready", ifa.in_ready, 1);
        check("arst_out_byte", ifa.out_byte, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        cap_a = '0;
        send(32'h43423234, 32'h0A4CD995);
        repeat (8) step();
        check("arst_recover", cap_a, 64'h85E813540F0AB405);

        begin
            int n0;
            n0 = nacc;
            in_l = $urandom;
            in_r = $urandom;
            in_valid = 1'b1;
            repeat (22) step();
            in_valid = 1'b0;
            check("b2b_count", nacc - n0, 3);
            check("b2b_gap", acc_gap, 9);
            drain("b2b_drain");
        end

        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            in_l = $urandom;
            in_r = $urandom;
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        drain("rand_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
